tone_gen: RTL

- Downstream consumer of the song sequencer's 16-bit note word (`songout`).
- Converts that word, a half-period count in clk50 cycles, into a 1-bit square wave and a 16-bit signed, enveloped audio sample for the DAC/PWM stage.
- Period changes take effect only at half-cycle boundaries (glitch-free).
- A zero word means rest, which silences the output.

---
 rtl/synth_pkg.sv | 23 ++
 rtl/tone_gen_if.sv | 18 +
 rtl/tone_gen_env_decay.sv | 58 +++++
 rtl/tone_gen.sv | 116 +++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants for the synthesiser voice: FSM encoding, rest word, widths.
// Also provides the sample formatting helper used by tone_gen.
// Ports: none (package).
package synth_pkg;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PLAY = 1'b1;

   // Note word meaning "rest": silence the voice.
   localparam logic [15:0] REST = 16'd0;

   localparam int ENV_W    = 8;
   localparam int SAMPLE_W = 16;

   // Square level times envelope, scaled by 128 so ENV_MAX=255 reaches +/-32640.
   function automatic logic signed [SAMPLE_W-1:0] fmt_sample(input logic sq,
                                                             input logic [ENV_W-1:0] env);
      logic signed [SAMPLE_W-1:0] mag;
      mag = {1'b0, env, 7'b0};
      return sq ? mag : -mag;
   endfunction

endpackage

// File: rtl/tone_gen_if.sv
// Note-word / audio bundle between the song sequencer, tone_gen and the DAC stage.
// Ports: half_period (note word in), sq_out, sample, playing, note_start (audio out).
// master = sequencer/bench side, slave = tone_gen side.
interface tone_gen_if;
   import synth_pkg::*;

   logic [15:0]                half_period;
   logic                       sq_out;
   logic signed [SAMPLE_W-1:0] sample;
   logic                       playing;
   logic                       note_start;

   modport master (output half_period,
                   input  sq_out, sample, playing, note_start);

   modport slave  (input  half_period,
                   output sq_out, sample, playing, note_start);
endinterface

// File: rtl/tone_gen_env_decay.sv
// Envelope generator: loads ENV_MAX on note start, decays by one every DECAY_DIV
// cycles while running, never below ENV_FLOOR; cleared to 0 when not running.
// Ports: clk50, reset (async active-low), load, run -> env[7:0]. No backpressure.
module env_decay
   import synth_pkg::*;
#(
   parameter int DECAY_DIV = 50000,
   parameter int ENV_MAX   = 255,
   parameter int ENV_FLOOR = 64
) (
   input  logic             clk50,
   input  logic             reset,
   input  logic             load,
   input  logic             run,
   output logic [ENV_W-1:0] env
);

   localparam int               DIV_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DECAY_DIV - 1);
   localparam logic [ENV_W-1:0] ENV_TOP  = ENV_W'(ENV_MAX);
   localparam logic [ENV_W-1:0] ENV_LO   = ENV_W'(ENV_FLOOR);

   logic [DIV_W-1:0] div_q, div_d;
   logic [ENV_W-1:0] env_q, env_d;

   always_comb begin
      div_d = div_q;
      env_d = env_q;
      // load wins over a simultaneous divider wrap: a retrigger always restarts at the top.
      if (load) begin
         div_d = '0;
         env_d = ENV_TOP;
      end else if (!run) begin
         div_d = '0;
         env_d = '0;
      end else if (div_q == DIV_LAST) begin
         div_d = '0;
         if (env_q > ENV_LO) begin
            env_d = env_q - 1'b1;
         end
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         div_q <= '0;
         env_q <= '0;
      end else begin
         div_q <= div_d;
         env_q <= env_d;
      end
   end

   assign env = env_q;

endmodule

// File: rtl/tone_gen.sv
// Square-wave voice: turns a half-period note word into sq_out and an enveloped sample.
// Latency: sq_out rises 2 clocks after a nonzero word, sample follows sq_out by 1 clock.
// Ports: clk50, reset (async active-low), bus (slave: half_period in, audio out). No backpressure.
module tone_gen
   import synth_pkg::*;
#(
   parameter int DECAY_DIV = 50000,
   parameter int ENV_MAX   = 255,
   parameter int ENV_FLOOR = 64
) (
   input  logic       clk50,
   input  logic       reset,
   tone_gen_if.slave  bus
);

   logic [15:0]                hp_q;
   logic [0:0]                 state_q, state_d;
   logic [15:0]                active_q, active_d;
   logic [15:0]                cnt_q, cnt_d;
   logic                       sq_q, sq_d;
   logic                       ns_q, ns_d;
   logic signed [SAMPLE_W-1:0] sample_q;
   logic                       boundary;
   logic                       env_load;
   logic                       env_run;
   logic [ENV_W-1:0]           env;

   // active is never 0 in PLAY, so active-1 cannot wrap there.
   assign boundary = (cnt_q == (active_q - 16'd1));

   always_comb begin
      state_d  = state_q;
      active_d = active_q;
      cnt_d    = cnt_q;
      sq_d     = sq_q;
      ns_d     = 1'b0;
      env_load = 1'b0;
      env_run  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            sq_d  = 1'b0;
            if (hp_q != REST) begin
               state_d  = ST_PLAY;
               active_d = hp_q;
               sq_d     = 1'b1;
               ns_d     = 1'b1;
               env_load = 1'b1;
               env_run  = 1'b1;
            end
         end
         ST_PLAY: begin
            env_run = 1'b1;
            if (boundary) begin
               // Note word is only examined here so every half-cycle completes intact.
               cnt_d = '0;
               sq_d  = ~sq_q;
               if (hp_q == REST) begin
                  state_d = ST_IDLE;
                  sq_d    = 1'b0;
                  env_run = 1'b0;
               end else if (hp_q != active_q) begin
                  active_d = hp_q;
                  ns_d     = 1'b1;
                  env_load = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk50 or negedge reset) begin
      if (!reset) begin
         hp_q     <= '0;
         state_q  <= ST_IDLE;
         active_q <= '0;
         cnt_q    <= '0;
         sq_q     <= 1'b0;
         ns_q     <= 1'b0;
         sample_q <= '0;
      end else begin
         hp_q     <= bus.half_period;
         state_q  <= state_d;
         active_q <= active_d;
         cnt_q    <= cnt_d;
         sq_q     <= sq_d;
         ns_q     <= ns_d;
         // Built from the registered sq/env, so it lags them by one clock and
         // naturally reads 0 once env has been cleared on entry to IDLE.
         sample_q <= fmt_sample(sq_q, env);
      end
   end

   env_decay #(
      .DECAY_DIV (DECAY_DIV),
      .ENV_MAX   (ENV_MAX),
      .ENV_FLOOR (ENV_FLOOR)
   ) u_env (
      .clk50 (clk50),
      .reset (reset),
      .load  (env_load),
      .run   (env_run),
      .env   (env)
   );

   assign bus.sq_out     = sq_q;
   assign bus.sample     = sample_q;
   assign bus.playing    = (state_q == ST_PLAY);
   assign bus.note_start = ns_q;

endmodule
